// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register count of in-flight writers. Stall is derived
// from the counts, so the block is independent of pipeline depth and memory
// latency. Counts move up on issue and down on writeback or squash.
module reg_scoreboard #(
  parameter int NUM_REGS    = 16,
  parameter int REG_ADDR_W  = 4,
  parameter int MAX_PENDING = 3,
  parameter int WB_BYPASS   = 1,
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wb_en,
  input  logic [REG_ADDR_W-1:0] issue_dst,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  has_src1,
  input  logic                  has_src2,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dst,
  input  logic                  cancel_valid,
  input  logic [REG_ADDR_W-1:0] cancel_dst,
  output logic                  stall,
  output logic                  issue_fire,
  output logic                  pending_any,
  output logic                  underflow_err
);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             pending_q;
  logic             pending_d;
  logic             underflow_q;
  logic             underflow_d;
  logic             hazard_s;
  logic             sat_s;
  logic             stall_s;
  logic             fire_s;

  // True when a single source read of register r must wait. A count of one
  // can be released by a same-cycle writeback only with a write-first file.
  function automatic logic src_blocked(input logic [CNT_W-1:0] cnt,
                                       input logic             wb_hit);
    logic blk;
    if (int'(cnt) >= 2) begin
      blk = 1'b1;
    end else if (int'(cnt) == 1) begin
      blk = !((WB_BYPASS != 0) && wb_hit);
    end else begin
      blk = 1'b0;
    end
    return blk;
  endfunction

  // Hazard and saturation detection from registered counts; addresses
  // beyond NUM_REGS never match a loop index and so never stall.
  always_comb begin
    hazard_s = 1'b0;
    sat_s    = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (has_src1 && (src1 == REG_ADDR_W'(r))) begin
        hazard_s = hazard_s | src_blocked(cnt_q[r], wb_valid && (wb_dst == REG_ADDR_W'(r)));
      end else begin
        hazard_s = hazard_s;
      end
      if (has_src2 && (src2 == REG_ADDR_W'(r))) begin
        hazard_s = hazard_s | src_blocked(cnt_q[r], wb_valid && (wb_dst == REG_ADDR_W'(r)));
      end else begin
        hazard_s = hazard_s;
      end
      if (issue_wb_en && (issue_dst == REG_ADDR_W'(r)) && (int'(cnt_q[r]) == MAX_PENDING)) begin
        sat_s = 1'b1;
      end else begin
        sat_s = sat_s;
      end
    end
    stall_s = issue_valid & (hazard_s | sat_s);
    fire_s  = issue_valid & ~stall_s;
  end

  // Net count update per register; decrements below zero clamp and flag.
  always_comb begin
    underflow_d = underflow_q;
    pending_d   = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      int sum;
      sum = int'(cnt_q[r]);
      if (fire_s && issue_wb_en && (issue_dst == REG_ADDR_W'(r))) begin
        sum = sum + 1;
      end else begin
        sum = sum;
      end
      if (wb_valid && (wb_dst == REG_ADDR_W'(r))) begin
        sum = sum - 1;
      end else begin
        sum = sum;
      end
      if (cancel_valid && (cancel_dst == REG_ADDR_W'(r))) begin
        sum = sum - 1;
      end else begin
        sum = sum;
      end
      if (sum < 0) begin
        cnt_d[r]    = '0;
        underflow_d = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(sum);
      end
      pending_d = pending_d | (cnt_d[r] != '0);
    end
  end

  // State registers; reset clears every count and the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      pending_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      pending_q   <= pending_d;
      underflow_q <= underflow_d;
    end
  end

  assign stall         = stall_s;
  assign issue_fire    = fire_s;
  assign pending_any   = pending_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a cycle-by-cycle vector table run
// against a write-first instance and a non-bypass instance side by side.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_wb_en, has_src1, has_src2;
  logic       wb_valid, cancel_valid;
  logic [3:0] issue_dst, src1, src2, wb_dst, cancel_dst;
  logic       stall, issue_fire, pending_any, underflow_err;
  logic       stall_nb, fire_nb, pending_nb, underflow_nb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NUM_REGS(16), .REG_ADDR_W(4), .MAX_PENDING(3), .WB_BYPASS(1)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_dst(issue_dst), .src1(src1), .src2(src2), .has_src1(has_src1),
    .has_src2(has_src2), .wb_valid(wb_valid), .wb_dst(wb_dst),
    .cancel_valid(cancel_valid), .cancel_dst(cancel_dst), .stall(stall),
    .issue_fire(issue_fire), .pending_any(pending_any), .underflow_err(underflow_err)
  );

  reg_scoreboard #(.NUM_REGS(16), .REG_ADDR_W(4), .MAX_PENDING(3), .WB_BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_dst(issue_dst), .src1(src1), .src2(src2), .has_src1(has_src1),
    .has_src2(has_src2), .wb_valid(wb_valid), .wb_dst(wb_dst),
    .cancel_valid(cancel_valid), .cancel_dst(cancel_dst), .stall(stall_nb),
    .issue_fire(fire_nb), .pending_any(pending_nb), .underflow_err(underflow_nb)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       iv, we;
    logic [3:0] dst, s1;
    logic       h1;
    logic [3:0] s2;
    logic       h2, wv;
    logic [3:0] wd;
    logic       cv;
    logic [3:0] cd;
    logic       e_stall, e_fire, e_pend, e_uf, e_stall_nb;
  } vec_t;

  vec_t vecs[$];

  // One row = one clock: inputs, then outputs expected before the edge.
  function automatic void add(string name, int r, int iv, int we, int dst,
                              int s1, int h1, int s2, int h2, int wv, int wd,
                              int cv, int cd, int es, int ef, int ep, int eu, int esn);
    vec_t v;
    v.name = name; v.rst = r[0]; v.iv = iv[0]; v.we = we[0]; v.dst = dst[3:0];
    v.s1 = s1[3:0]; v.h1 = h1[0]; v.s2 = s2[3:0]; v.h2 = h2[0];
    v.wv = wv[0]; v.wd = wd[3:0]; v.cv = cv[0]; v.cd = cd[3:0];
    v.e_stall = es[0]; v.e_fire = ef[0]; v.e_pend = ep[0]; v.e_uf = eu[0];
    v.e_stall_nb = esn[0];
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dst = 4'd0;
    src1 = 4'd0; src2 = 4'd0; has_src1 = 1'b0; has_src2 = 1'b0;
    wb_valid = 1'b0; wb_dst = 4'd0; cancel_valid = 1'b0; cancel_dst = 4'd0;
  endtask

  initial begin
    //  name          rst iv we dst s1 h1 s2 h2 wv wd cv cd | st fi pe uf stnb
    add("idle_issue",   0, 1, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add("idle_after",   0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // RAW on r5, writeback in cycle 4
    add("raw_c0",       0, 1, 1, 5,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add("raw_c1",       0, 1, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add("raw_c2",       0, 1, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add("raw_c3",       0, 1, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add("raw_c4_wb",    0, 1, 0, 0,  5, 1, 0, 0, 1, 5, 0, 0,  0, 1, 1, 0, 1);
    add("raw_c5",       0, 1, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    // two writers of r2, read through src2
    add("multi_iss1",   0, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add("multi_iss2",   0, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add("multi_ge2_wb", 0, 1, 0, 0,  0, 0, 2, 1, 1, 2, 0, 0,  1, 0, 1, 0, 1);
    add("multi_one",    0, 1, 0, 0,  0, 0, 2, 1, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add("multi_wb2",    0, 1, 0, 0,  0, 0, 2, 1, 1, 2, 0, 0,  0, 1, 1, 0, 1);
    add("multi_clear",  0, 1, 0, 0,  0, 0, 2, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    // saturation on r7
    add("sat_iss1",     0, 1, 1, 7,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add("sat_iss2",     0, 1, 1, 7,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add("sat_iss3",     0, 1, 1, 7,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add("sat_full_wb",  0, 1, 1, 7,  0, 0, 0, 0, 1, 7, 0, 0,  1, 0, 1, 0, 1);
    add("sat_cnt2",     0, 1, 1, 7,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    add("sat_full",     0, 1, 1, 7,  0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add("sat_drain1",   0, 0, 0, 0,  0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 1, 0, 0);
    add("sat_drain2",   0, 0, 0, 0,  0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 1, 0, 0);
    add("sat_drain3",   0, 0, 0, 0,  0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 1, 0, 0);
    // issue, writeback and cancel of r4 together
    add("sim_iss",      0, 1, 1, 4,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add("sim_all3",     0, 1, 1, 4,  0, 0, 0, 0, 1, 4, 1, 4,  0, 1, 1, 0, 0);
    add("sim_after",    0, 1, 0, 0,  4, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    // cancel does not release a hazard in its own cycle
    add("cxl_iss",      0, 1, 1, 6,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add("cxl_same",     0, 1, 0, 0,  6, 1, 0, 0, 0, 0, 1, 6,  1, 0, 1, 0, 1);
    add("cxl_after",    0, 1, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    // underflow on r9 is sticky
    add("uf_cancel",    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 9,  0, 0, 0, 0, 0);
    add("uf_set",       0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    add("uf_sticky",    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    // unused sources never stall
    add("nosrc_iss",    0, 1, 1, 3,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0);
    add("nosrc_read",   0, 1, 0, 0,  3, 0, 3, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0);
    // reset in the middle of a hazard
    add("rst_mid",      1, 1, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 1);
    add("rst_after",    0, 1, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    // a stalled issue must not count its destination
    add("blk_iss",      0, 1, 1, 5,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add("blk_stalled",  0, 1, 1, 8,  5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1);
    add("blk_wb",       0, 0, 0, 0,  0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 1, 0, 0);
    add("blk_empty",    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      issue_valid = vecs[i].iv;  issue_wb_en = vecs[i].we; issue_dst = vecs[i].dst;
      src1        = vecs[i].s1;  has_src1    = vecs[i].h1;
      src2        = vecs[i].s2;  has_src2    = vecs[i].h2;
      wb_valid    = vecs[i].wv;  wb_dst      = vecs[i].wd;
      cancel_valid = vecs[i].cv; cancel_dst  = vecs[i].cd;
      #2;
      chk({vecs[i].name, ".stall"},    stall,         vecs[i].e_stall);
      chk({vecs[i].name, ".fire"},     issue_fire,    vecs[i].e_fire);
      chk({vecs[i].name, ".pending"},  pending_any,   vecs[i].e_pend);
      chk({vecs[i].name, ".underflow"}, underflow_err, vecs[i].e_uf);
      chk({vecs[i].name, ".stall_nb"}, stall_nb,      vecs[i].e_stall_nb);
    end

    // Hand sequence: fill r12 to the limit while a second register (r13)
    // is also pending, then retire r13 and check r12 alone keeps saturation.
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dst = 4'd13;
    #2;
    chk("seq_r13_fire", issue_fire, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      issue_dst = 4'd12;
      #2;
      chk("seq_r12_fill", issue_fire, 1'b1);
    end
    @(negedge clk);
    issue_dst = 4'd12; wb_valid = 1'b1; wb_dst = 4'd13;
    #2;
    chk("seq_r12_sat", stall, 1'b1);
    @(negedge clk);
    issue_dst = 4'd13; wb_valid = 1'b0;
    #2;
    chk("seq_r13_free", stall, 1'b0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("seq_rst_pend", pending_any, 1'b0);
    chk("seq_rst_pend_nb", pending_nb, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
